// File: rtl/img_pkg.sv
// Shared geometry, memory map and dump-state type for the image memory block.
package img_pkg;

    localparam int IMG_W       = 352;
    localparam int IMG_H       = 288;
    // Four 8-bit pixels are packed into each 32-bit word.
    localparam int IMG_WORDS   = (IMG_W * IMG_H) / 4;
    // The result image sits directly after the source image.
    localparam int RESULT_BASE = IMG_WORDS;
    localparam int DEPTH       = 2 * IMG_WORDS;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int PTR_W  = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } dump_state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with a one-cycle registered read.
// The array and the read register carry no reset so the storage maps onto block RAM.
module ram_sp
    import img_pkg::*;
#(
    parameter int WORDS = img_pkg::DEPTH,
    parameter int AW    = img_pkg::ADDR_W,
    parameter int DW    = img_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [WORDS];
    logic [DW-1:0] rdata_reg;

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/image_mem_resp.sv
// Image memory with an accelerator port and a ready/valid dump of the result image.
// The accelerator always owns the RAM port; the dump only reads when the port is free.
module image_mem_resp
    import img_pkg::*;
#(
    parameter int DEPTH       = img_pkg::DEPTH,
    parameter int RESULT_BASE = img_pkg::RESULT_BASE,
    parameter int IMG_WORDS   = img_pkg::IMG_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] dataW,
    output logic [31:0] dataR,
    input  logic        dump_image,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic        dump_last,
    output logic        dump_busy,
    output logic        addr_err
);

    localparam logic [16:0]      DEPTH_L  = 17'(DEPTH);
    localparam logic [15:0]      BASE_L   = 16'(RESULT_BASE);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IMG_WORDS - 1);

    dump_state_t      state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic             dump_valid_reg, dump_valid_next;
    logic             dump_last_reg, dump_last_next;
    logic             load_rd_reg, load_rd_next;
    logic [31:0]      dump_hold_reg;
    logic             rd_hit_reg;
    logic [31:0]      data_hold_reg;
    logic             addr_err_reg;
    logic             dump_prev_reg;
    logic             armed_reg;

    logic        in_range;
    logic        acc_rd;
    logic        acc_wr;
    logic        dump_rd;
    logic        dump_start;
    logic        ram_we;
    logic        ram_re;
    logic [15:0] ram_addr;
    logic [15:0] dump_addr;
    logic [31:0] ram_q;

    assign in_range  = ({1'b0, addr} < DEPTH_L);
    assign acc_rd    = en & ~we;
    assign acc_wr    = en & we;
    assign dump_addr = BASE_L + {1'b0, ptr_reg};

    // A dump starts on a rising edge of dump_image, but only once dump_image has
    // been seen low since reset, so a trigger held high across reset cannot restart.
    assign dump_start = dump_image & ~dump_prev_reg & armed_reg;

    // Dump FSM next state, pointer and stream-register updates.
    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        dump_valid_next = dump_valid_reg;
        dump_last_next  = dump_last_reg;
        load_rd_next    = 1'b0;
        dump_rd         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dump_start) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                end
            end
            LOAD: begin
                if (!en) begin
                    dump_rd         = 1'b1;
                    load_rd_next    = 1'b1;
                    state_next      = STREAM;
                    dump_valid_next = 1'b1;
                    dump_last_next  = (ptr_reg == LAST_PTR);
                end
            end
            STREAM: begin
                if (dump_valid_reg && dump_ready) begin
                    dump_valid_next = 1'b0;
                    dump_last_next  = 1'b0;
                    if (dump_last_reg) begin
                        state_next = IDLE;
                    end else begin
                        ptr_next   = ptr_reg + 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // RAM port mux: the accelerator wins whenever en is high.
    always_comb begin
        ram_we   = acc_wr & in_range;
        ram_re   = (acc_rd & in_range) | dump_rd;
        ram_addr = en ? addr : dump_addr;
    end

    ram_sp #(
        .WORDS (DEPTH),
        .AW    (16),
        .DW    (32)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (dataW),
        .rdata (ram_q)
    );

    // The RAM output register is shared, so each consumer takes it only in the cycle
    // after its own read and otherwise shows its private hold register.
    assign dataR     = rd_hit_reg  ? ram_q : data_hold_reg;
    assign dump_data = load_rd_reg ? ram_q : dump_hold_reg;

    // State, pointer, hold registers and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            dump_valid_reg <= 1'b0;
            dump_last_reg  <= 1'b0;
            load_rd_reg    <= 1'b0;
            dump_hold_reg  <= '0;
            rd_hit_reg     <= 1'b0;
            data_hold_reg  <= '0;
            addr_err_reg   <= 1'b0;
            dump_prev_reg  <= 1'b0;
            armed_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            dump_valid_reg <= dump_valid_next;
            dump_last_reg  <= dump_last_next;
            load_rd_reg    <= load_rd_next;
            dump_hold_reg  <= dump_data;
            rd_hit_reg     <= acc_rd & in_range;
            // An out-of-range read returns zero on the following cycle.
            data_hold_reg  <= (acc_rd && !in_range) ? 32'h0 : dataR;
            if (en && !in_range) begin
                addr_err_reg <= 1'b1;
            end
            dump_prev_reg  <= dump_image;
            if (!dump_image) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign dump_valid = dump_valid_reg;
    assign dump_last  = dump_last_reg;
    assign dump_busy  = (state_reg != IDLE);
    assign addr_err   = addr_err_reg;

endmodule

// File: tb/tb_image_mem_resp.sv
// Self-checking bench for image_mem_resp: directed scenarios plus randomized
// accelerator traffic and sink back-pressure against a flat array model.
module tb_image_mem_resp;
    import img_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] dataW = '0;
    logic [31:0] dataR;
    logic        dump_image = 1'b0;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        dump_busy;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain memory array plus the expected read-data value.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_data_r = '0;

    image_mem_resp dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .we         (we),
        .addr       (addr),
        .dataW      (dataW),
        .dataR      (dataR),
        .dump_image (dump_image),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .dump_busy  (dump_busy),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_idle();
        en = 1'b0; we = 1'b0; addr = '0; dataW = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; acc_idle(); dump_image = 1'b0; dump_ready = 1'b0;
        tick(); tick();
        checks++; if (dataR !== 32'h0) begin errors++; $display("FAIL reset_dataR actual=%h required=0", dataR); end
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid actual=%b required=0", dump_valid); end
        checks++; if (dump_data !== 32'h0) begin errors++; $display("FAIL reset_dump_data actual=%h required=0", dump_data); end
        checks++; if (dump_last !== 1'b0) begin errors++; $display("FAIL reset_dump_last actual=%b required=0", dump_last); end
        checks++; if (dump_busy !== 1'b0) begin errors++; $display("FAIL reset_dump_busy actual=%b required=0", dump_busy); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err actual=%b required=0", addr_err); end
        reset = 1'b0;
        tick();
        exp_data_r = 32'h0;
        $display("reset: outputs checked after synchronous reset");
    endtask

    task automatic test_write_read();
        logic [15:0] a_list [8];
        // Directed word: write then read with latency 1, then hold over idle cycles.
        en = 1'b1; we = 1'b1; addr = 16'h0010; dataW = 32'hDEADBEEF;
        model_mem[16'h0010] = 32'hDEADBEEF;
        tick();
        checks++; if (dataR !== exp_data_r) begin errors++; $display("FAIL write_holds_dataR actual=%h required=%h", dataR, exp_data_r); end
        en = 1'b1; we = 1'b0; addr = 16'h0010;
        tick();
        exp_data_r = model_mem[16'h0010];
        checks++; if (dataR !== 32'hDEADBEEF) begin errors++; $display("FAIL read_latency1 actual=%h required=deadbeef", dataR); end
        $display("read  addr=0010 data=%h", dataR);
        acc_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dataR !== exp_data_r) begin errors++; $display("FAIL idle_hold_%0d actual=%h required=%h", i, dataR, exp_data_r); end
        end
        // Random in-range writes followed by reads in reverse order.
        for (int i = 0; i < 8; i++) begin
            a_list[i] = 16'($urandom_range(32, DEPTH - 1));
            en = 1'b1; we = 1'b1; addr = a_list[i]; dataW = $urandom;
            model_mem[a_list[i]] = dataW;
            tick();
            checks++; if (dataR !== exp_data_r) begin errors++; $display("FAIL rand_write_hold actual=%h required=%h", dataR, exp_data_r); end
            $display("write addr=%h data=%h", a_list[i], model_mem[a_list[i]]);
        end
        for (int i = 7; i >= 0; i--) begin
            en = 1'b1; we = 1'b0; addr = a_list[i];
            tick();
            exp_data_r = model_mem[a_list[i]];
            checks++; if (dataR !== exp_data_r) begin errors++; $display("FAIL rand_read addr=%h actual=%h required=%h", a_list[i], dataR, exp_data_r); end
            $display("read  addr=%h data=%h", a_list[i], dataR);
        end
        acc_idle();
        tick();
    endtask

    task automatic test_addr_err();
        logic [31:0] top_word;
        top_word = $urandom;
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_clear actual=%b required=0", addr_err); end
        en = 1'b1; we = 1'b1; addr = 16'(DEPTH - 1); dataW = top_word;
        model_mem[DEPTH - 1] = top_word;
        tick();
        en = 1'b1; we = 1'b0; addr = 16'(DEPTH - 1);
        tick();
        exp_data_r = top_word;
        checks++; if (dataR !== exp_data_r) begin errors++; $display("FAIL last_word_read actual=%h required=%h", dataR, exp_data_r); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_inrange actual=%b required=0", addr_err); end
        // Out-of-range write is dropped and flags the error.
        en = 1'b1; we = 1'b1; addr = 16'hFFFF; dataW = 32'h12345678;
        tick();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_set actual=%b required=1", addr_err); end
        en = 1'b1; we = 1'b0; addr = 16'hC600;
        tick();
        exp_data_r = 32'h0;
        checks++; if (dataR !== 32'h0) begin errors++; $display("FAIL oob_read_zero actual=%h required=0", dataR); end
        $display("read  addr=c600 data=%h addr_err=%b", dataR, addr_err);
        en = 1'b1; we = 1'b0; addr = 16'(DEPTH - 1);
        tick();
        exp_data_r = model_mem[DEPTH - 1];
        checks++; if (dataR !== exp_data_r) begin errors++; $display("FAIL oob_write_dropped actual=%h required=%h", dataR, exp_data_r); end
        acc_idle();
        repeat (3) tick();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_sticky actual=%b required=1", addr_err); end
        // Reset clears the flag but keeps memory.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_data_r = 32'h0;
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_reset actual=%b required=0", addr_err); end
        en = 1'b1; we = 1'b0; addr = 16'h0010;
        tick();
        exp_data_r = model_mem[16'h0010];
        checks++; if (dataR !== exp_data_r) begin errors++; $display("FAIL mem_kept_over_reset actual=%h required=%h", dataR, exp_data_r); end
        acc_idle();
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < IMG_WORDS; i++) begin
            en = 1'b1; we = 1'b1; addr = 16'(RESULT_BASE + i); dataW = 32'(i + 1);
            model_mem[RESULT_BASE + i] = 32'(i + 1);
            tick();
        end
        acc_idle();
        tick();
        $display("fill: %0d result words written", IMG_WORDS);
    endtask

    task automatic test_dump_full();
        int  idx = 0;
        int  cyc = 0;
        int  stall_cnt = 0;
        int  en_hold = 0;
        bit  done = 1'b0;
        bit  rd_pend = 1'b0;
        bit  forced_prev = 1'b0;
        bit  retrig_done = 1'b0;
        logic [15:0] rd_addr = '0;
        dump_ready = 1'b0;
        dump_image = 1'b1;
        tick();
        dump_image = 1'b0;
        while (!done && cyc < 60000) begin
            if (rd_pend) begin
                exp_data_r = model_mem[rd_addr];
            end
            checks++; if (dataR !== exp_data_r) begin errors++; $display("FAIL dump_acc_dataR addr=%h actual=%h required=%h", rd_addr, dataR, exp_data_r); end
            if (forced_prev) begin
                checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL load_stall_valid actual=%b required=0", dump_valid); end
            end
            if (dump_valid === 1'b1) begin
                checks++; if (dump_data !== model_mem[RESULT_BASE + idx]) begin errors++; $display("FAIL dump_word idx=%0d actual=%h required=%h", idx, dump_data, model_mem[RESULT_BASE + idx]); end
                checks++; if (dump_last !== (idx == IMG_WORDS - 1)) begin errors++; $display("FAIL dump_last idx=%0d actual=%b required=%b", idx, dump_last, (idx == IMG_WORDS - 1)); end
                checks++; if (dump_busy !== 1'b1) begin errors++; $display("FAIL dump_busy_stream actual=%b required=1", dump_busy); end
            end
            // Choose next-cycle inputs.
            acc_idle();
            rd_pend = 1'b0;
            forced_prev = 1'b0;
            dump_image = 1'b0;
            if (idx == 30 && !retrig_done) begin
                dump_image = 1'b1;
                retrig_done = 1'b1;
            end
            if (dump_valid === 1'b1) begin
                if (idx == 7 && stall_cnt < 5) begin
                    dump_ready = 1'b0;
                    stall_cnt++;
                    $display("stall word=%0d data=%h cycle=%0d", idx, dump_data, stall_cnt);
                end else begin
                    dump_ready = (idx < 2000) ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (dump_ready) begin
                    if (idx % 1024 == 0 || idx == IMG_WORDS - 1) begin
                        $display("dump  word=%0d data=%h last=%b", idx, dump_data, dump_last);
                    end
                    idx++;
                end
                if (idx < 2000 && $urandom_range(0, 7) == 0) begin
                    en = 1'b1; we = 1'b0; rd_addr = 16'($urandom_range(0, DEPTH - 1)); addr = rd_addr; rd_pend = 1'b1;
                end
            end else if (dump_busy === 1'b1) begin
                dump_ready = 1'b0;
                if (idx == 20 && en_hold < 4) begin
                    en = 1'b1; we = 1'b0; rd_addr = 16'($urandom_range(0, DEPTH - 1)); addr = rd_addr;
                    rd_pend = 1'b1; forced_prev = 1'b1; en_hold++;
                    $display("load stall cycle=%0d acc read addr=%h", en_hold, rd_addr);
                end else if (idx < 2000 && $urandom_range(0, 7) == 0) begin
                    en = 1'b1; we = 1'b0; rd_addr = 16'($urandom_range(0, DEPTH - 1)); addr = rd_addr; rd_pend = 1'b1;
                end
            end else begin
                done = 1'b1;
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        acc_idle();
        dump_ready = 1'b0;
        dump_image = 1'b0;
        checks++; if (idx != IMG_WORDS) begin errors++; $display("FAIL dump_word_count actual=%0d required=%0d", idx, IMG_WORDS); end
        checks++; if (dump_busy !== 1'b0) begin errors++; $display("FAIL dump_busy_end actual=%b required=0", dump_busy); end
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL dump_valid_end actual=%b required=0", dump_valid); end
        checks++; if (stall_cnt != 5 || en_hold != 4) begin errors++; $display("FAIL dump_scenarios_hit stall=%0d required=5 en_hold=%0d required=4", stall_cnt, en_hold); end
        repeat (4) tick();
        checks++; if (dump_busy !== 1'b0) begin errors++; $display("FAIL dump_no_restart actual=%b required=0", dump_busy); end
        $display("dump: %0d words in %0d cycles", idx, cyc);
    endtask

    task automatic test_reset_mid_dump();
        int  idx = 0;
        int  cyc = 0;
        bit  hit = 1'b0;
        bit  seen = 1'b0;
        acc_idle();
        dump_ready = 1'b1;
        dump_image = 1'b1;
        while (!hit && cyc < 2000) begin
            tick();
            cyc++;
            if (dump_valid === 1'b1) begin
                if (idx == 99) begin
                    checks++; if (dump_data !== model_mem[RESULT_BASE + idx]) begin errors++; $display("FAIL abort_word actual=%h required=%h", dump_data, model_mem[RESULT_BASE + idx]); end
                    reset = 1'b1;
                    dump_ready = 1'b0;
                    hit = 1'b1;
                end else begin
                    idx++;
                end
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach_word100 actual=%0d required=99", idx); end
        tick();
        reset = 1'b0;
        dump_ready = 1'b1;
        exp_data_r = 32'h0;
        checks++; if (dataR !== 32'h0) begin errors++; $display("FAIL abort_dataR actual=%h required=0", dataR); end
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL abort_valid actual=%b required=0", dump_valid); end
        checks++; if (dump_data !== 32'h0) begin errors++; $display("FAIL abort_data actual=%h required=0", dump_data); end
        checks++; if (dump_last !== 1'b0) begin errors++; $display("FAIL abort_last actual=%b required=0", dump_last); end
        checks++; if (dump_busy !== 1'b0) begin errors++; $display("FAIL abort_busy actual=%b required=0", dump_busy); end
        $display("abort: reset at word %0d", idx + 1);
        repeat (10) begin
            tick();
            checks++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin errors++; $display("FAIL held_trigger_restart busy=%b valid=%b required=0", dump_busy, dump_valid); end
        end
        dump_image = 1'b0;
        tick();
        dump_image = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (dump_valid === 1'b1) begin
                seen = 1'b1;
                checks++; if (dump_data !== model_mem[RESULT_BASE]) begin errors++; $display("FAIL restart_first_word actual=%h required=%h", dump_data, model_mem[RESULT_BASE]); end
                checks++; if (dump_last !== 1'b0) begin errors++; $display("FAIL restart_last actual=%b required=0", dump_last); end
                $display("restart word=0 data=%h", dump_data);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL restart_timeout actual=no_valid required=valid"); end
        reset = 1'b1;
        dump_image = 1'b0;
        dump_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (dump_busy !== 1'b0) begin errors++; $display("FAIL final_idle actual=%b required=0", dump_busy); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_err();
        test_fill();
        test_dump_full();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
